cam_capture: RTL and testbench



---
 rtl/cam_capture.sv | 189 ++++++++++++++++++
 tb/tb_cam_capture.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture.sv
`timescale 1ns / 1ps
// Camera capture stage: synchronizes the camera bus into clk, pairs bytes into 16-bit
// pixels, decimates the frame by 2**DEC_LOG2 per axis and emits frame RAM write strokes.
module cam_capture #(
  parameter int unsigned XCLK_HALF = 1,
  parameter int unsigned DEC_LOG2  = 2,
  parameter int unsigned OUT_DIM   = 128,
  localparam int unsigned AddrW    = $clog2(OUT_DIM)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               pclk_i,
  input  logic               href_i,
  input  logic               vref_i,
  input  logic [7:0]         digital_i,
  input  logic               run_i,
  output logic               xclk_o,
  output logic [15:0]        pixel_o,
  output logic [2*AddrW:0]   wraddr_o,
  output logic               wren_o,
  output logic               frame_done_o,
  output logic               busy_o
);

  localparam int unsigned XcntW = (XCLK_HALF > 1) ? $clog2(XCLK_HALF) : 1;
  localparam logic [9:0] DecMask = 10'((1 << DEC_LOG2) - 1);

  typedef enum logic [1:0] {StIdle, StWaitBlank, StArmed, StCapture} state_e;

  // xclk divider
  logic [XcntW-1:0] xcnt_q, xcnt_d;
  logic             xclk_q, xclk_d;

  // Synchronizer stages, bit order {vref, href, pclk}; stage 3 is the previous sample.
  logic [2:0] sync1_q, sync2_q, sync3_q;
  logic [7:0] dig1_q, dig2_q;

  // Registered edge events, aligned with byte_q
  logic       pclk_rise_q, href_q, href_fall_q, vref_q, vref_rise_q, vref_fall_q;
  logic [7:0] byte_q;

  // Capture core
  state_e             state_q, state_d;
  logic [9:0]         x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic               phase_q, phase_d;
  logic [7:0]         hi_q, hi_d;
  logic [15:0]        pixel_q, pixel_d;
  logic [2*AddrW:0]   wraddr_q, wraddr_d;
  logic               wren_q, wren_d, fd_q, fd_d;
  logic [9:0]         x_sh, y_sh;
  logic               keep;

  // Free-running master clock divider, independent of capture state.
  always_comb begin
    xclk_d = xclk_q;
    xcnt_d = xcnt_q + XcntW'(1);
    if (xcnt_q == XcntW'(XCLK_HALF - 1)) begin
      xcnt_d = '0;
      xclk_d = ~xclk_q;
    end
  end

  // Input synchronizers and registered edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      xcnt_q      <= '0;
      xclk_q      <= 1'b0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync3_q     <= '0;
      dig1_q      <= '0;
      dig2_q      <= '0;
      pclk_rise_q <= 1'b0;
      href_q      <= 1'b0;
      href_fall_q <= 1'b0;
      vref_q      <= 1'b0;
      vref_rise_q <= 1'b0;
      vref_fall_q <= 1'b0;
      byte_q      <= '0;
    end else begin
      xcnt_q      <= xcnt_d;
      xclk_q      <= xclk_d;
      sync1_q     <= {vref_i, href_i, pclk_i};
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      dig1_q      <= digital_i;
      dig2_q      <= dig1_q;
      pclk_rise_q <= sync2_q[0] & ~sync3_q[0];
      href_q      <= sync2_q[1];
      href_fall_q <= ~sync2_q[1] & sync3_q[1];
      vref_q      <= sync2_q[2];
      vref_rise_q <= sync2_q[2] & ~sync3_q[2];
      vref_fall_q <= ~sync2_q[2] & sync3_q[2];
      byte_q      <= dig2_q;
    end
  end

  assign x_sh = x_cnt_q >> DEC_LOG2;
  assign y_sh = y_cnt_q >> DEC_LOG2;
  assign keep = ((x_cnt_q & DecMask) == '0) && ((y_cnt_q & DecMask) == '0) &&
                (x_sh < 10'(OUT_DIM)) && (y_sh < 10'(OUT_DIM));

  // Frame FSM, byte pairing and decimation; vref_rise wins over any data event.
  always_comb begin
    state_d  = state_q;
    x_cnt_d  = x_cnt_q;
    y_cnt_d  = y_cnt_q;
    phase_d  = phase_q;
    hi_d     = hi_q;
    pixel_d  = pixel_q;
    wraddr_d = wraddr_q;
    wren_d   = 1'b0;
    fd_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (run_i) state_d = StWaitBlank;
      end
      StWaitBlank: begin
        if (vref_q) state_d = StArmed;
      end
      StArmed: begin
        if (vref_fall_q) begin
          state_d = StCapture;
          x_cnt_d = '0;
          y_cnt_d = '0;
          phase_d = 1'b0;
        end
      end
      StCapture: begin
        if (vref_rise_q) begin
          fd_d    = 1'b1;
          state_d = run_i ? StArmed : StIdle;
        end else if (href_fall_q) begin
          // A dangling first byte of a pair is dropped here.
          y_cnt_d = (y_cnt_q == 10'h3FF) ? y_cnt_q : y_cnt_q + 10'd1;
          x_cnt_d = '0;
          phase_d = 1'b0;
        end else if (pclk_rise_q && href_q) begin
          if (!phase_q) begin
            hi_d    = byte_q;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            x_cnt_d = (x_cnt_q == 10'h3FF) ? x_cnt_q : x_cnt_q + 10'd1;
            if (keep) begin
              wren_d   = 1'b1;
              pixel_d  = {hi_q, byte_q};
              wraddr_d = {1'b0, y_sh[AddrW-1:0], x_sh[AddrW-1:0]};
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Capture state and registered write-port outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      x_cnt_q  <= '0;
      y_cnt_q  <= '0;
      phase_q  <= 1'b0;
      hi_q     <= '0;
      pixel_q  <= '0;
      wraddr_q <= '0;
      wren_q   <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_cnt_q  <= x_cnt_d;
      y_cnt_q  <= y_cnt_d;
      phase_q  <= phase_d;
      hi_q     <= hi_d;
      pixel_q  <= pixel_d;
      wraddr_q <= wraddr_d;
      wren_q   <= wren_d;
      fd_q     <= fd_d;
    end
  end

  assign xclk_o       = xclk_q;
  assign pixel_o      = pixel_q;
  assign wraddr_o     = wraddr_q;
  assign wren_o       = wren_q;
  assign frame_done_o = fd_q;
  assign busy_o       = (state_q == StArmed) || (state_q == StCapture);

endmodule

// File: tb/tb_cam_capture.sv
`timescale 1ns / 1ps
// Scoreboard bench for cam_capture: stimulus pushes expected writes, a monitor pops them.
module tb_cam_capture;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        pclk = 1'b0, href = 1'b0, vref = 1'b0, run = 1'b0;
  logic [7:0]  digital = 8'h00;
  logic        xclk, wren, frame_done, busy;
  logic [15:0] pixel;
  logic [14:0] wraddr;

  cam_capture dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .pclk_i      (pclk),
    .href_i      (href),
    .vref_i      (vref),
    .digital_i   (digital),
    .run_i       (run),
    .xclk_o      (xclk),
    .pixel_o     (pixel),
    .wraddr_o    (wraddr),
    .wren_o      (wren),
    .frame_done_o(frame_done),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [14:0] addr;
    logic [15:0] pix;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0, n_bad = 0, wr_cnt = 0, fd_cnt = 0, pat_mode = 0;
  logic [14:0] last_addr = '0;
  logic [15:0] last_pix = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (wren) begin
      wr_cnt++;
      last_addr = wraddr;
      last_pix  = pixel;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr 0x%0h pix 0x%0h expected no write",
                 wraddr, pixel);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {17'b0, wraddr}, {17'b0, e.addr});
        chk("wr_pixel", {16'b0, pixel}, {16'b0, e.pix});
      end
    end
    if (frame_done) fd_cnt++;
    if (wren && frame_done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wren_with_frame_done: got both high expected exclusive");
    end
  end

  function automatic logic [15:0] pix_val(input int y, input int x);
    logic [15:0] r;
    r = (pat_mode != 0) ? {8'(y), 8'(x)} : 16'hA53C;
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    pclk = 1'b0;
    digital = b;
    repeat (2) @(negedge clk);
    pclk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_px(input int y, input int x0, input int n, input bit exp);
    for (int x = x0; x < x0 + n; x++) begin
      logic [15:0] p;
      exp_t e;
      p = pix_val(y, x);
      if (exp && (x % 4 == 0) && (y % 4 == 0) && (x < 512) && (y < 512)) begin
        e.addr = {1'b0, 7'(y / 4), 7'(x / 4)};
        e.pix  = p;
        exp_q.push_back(e);
      end
      send_byte(p[15:8]);
      send_byte(p[7:0]);
    end
  endtask

  task automatic line_end();
    pclk = 1'b0;
    href = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_line(input int y, input int n, input bit exp);
    pclk = 1'b0;
    href = 1'b1;
    send_px(y, 0, n, exp);
    line_end();
  endtask

  task automatic frame_start();
    vref = 1'b1;
    repeat (8) @(negedge clk);
    vref = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame_end();
    vref = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, fd0;
    logic prev;

    // Reset held with toggling inputs
    repeat (20) begin
      @(negedge clk);
      pclk = ~pclk;
      href = 1'($urandom);
      vref = 1'($urandom);
      run = 1'($urandom);
      digital = 8'($urandom);
    end
    chk("rst_xclk", {31'b0, xclk}, 0);
    chk("rst_pixel", {16'b0, pixel}, 0);
    chk("rst_wraddr", {17'b0, wraddr}, 0);
    chk("rst_wren", {31'b0, wren}, 0);
    chk("rst_frame_done", {31'b0, frame_done}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    pclk = 1'b0; href = 1'b0; vref = 1'b0; run = 1'b0; digital = 8'h00;
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    prev = xclk;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("xclk_toggle", {31'b0, xclk}, {31'b0, ~prev});
      prev = xclk;
    end
    chk("idle_busy", {31'b0, busy}, 0);

    // Single line of constant pixels
    run = 1'b1;
    frame_start();
    chk("armed_busy", {31'b0, busy}, 1);
    base = wr_cnt;
    pat_mode = 0;
    send_line(0, 640, 1'b1);
    drain();
    chk("line_writes", wr_cnt - base, 128);
    chk("line_last_addr", {17'b0, last_addr}, 32'h7F);
    fd0 = fd_cnt;
    frame_end();
    chk("line_frame_done", fd_cnt - fd0, 1);

    // Short frame, wide lines: column cap at 128
    pat_mode = 1;
    frame_start();
    base = wr_cnt;
    for (int y = 0; y < 5; y++) send_line(y, 520, 1'b1);
    drain();
    chk("wide_writes", wr_cnt - base, 256);
    chk("wide_last_addr", {17'b0, last_addr}, 32'hFF);
    chk("wide_last_pix", {16'b0, last_pix}, 32'h04FC);
    fd0 = fd_cnt;
    frame_end();
    chk("wide_frame_done", fd_cnt - fd0, 1);

    // Tall frame, one pixel per line: row cap at 128
    frame_start();
    base = wr_cnt;
    for (int y = 0; y < 520; y++) send_line(y, 1, 1'b1);
    drain();
    chk("tall_writes", wr_cnt - base, 128);
    chk("tall_last_addr", {17'b0, last_addr}, 32'h3F80);
    chk("tall_last_pix", {16'b0, last_pix}, 32'hFC00);
    fd0 = fd_cnt;
    frame_end();
    chk("tall_frame_done", fd_cnt - fd0, 1);

    // Odd byte count: dangling byte dropped, phase restarts each line
    frame_start();
    base = wr_cnt;
    pclk = 1'b0;
    href = 1'b1;
    send_px(0, 0, 1, 1'b1);
    send_byte(8'hEE);
    line_end();
    for (int y = 1; y < 5; y++) send_line(y, 2, 1'b1);
    drain();
    chk("odd_writes", wr_cnt - base, 2);
    chk("odd_last_addr", {17'b0, last_addr}, 32'h80);
    chk("odd_last_pix", {16'b0, last_pix}, 32'h0400);
    frame_end();

    // run dropped mid-frame: frame completes, then idle
    fd0 = fd_cnt;
    frame_start();
    base = wr_cnt;
    send_line(0, 8, 1'b1);
    run = 1'b0;
    for (int y = 1; y < 5; y++) send_line(y, 8, 1'b1);
    frame_end();
    drain();
    chk("rundrop_writes", wr_cnt - base, 4);
    chk("rundrop_frame_done", fd_cnt - fd0, 1);
    chk("rundrop_busy", {31'b0, busy}, 0);
    base = wr_cnt;
    frame_start();
    send_line(0, 8, 1'b0);
    frame_end();
    drain();
    chk("idle_frame_writes", wr_cnt - base, 0);
    chk("idle_frame_done", fd_cnt - fd0, 1);

    // Reset pulsed mid-line
    run = 1'b1;
    frame_start();
    chk("prereset_busy", {31'b0, busy}, 1);
    base = wr_cnt;
    pclk = 1'b0;
    href = 1'b1;
    send_px(0, 0, 32, 1'b1);
    drain();
    chk("prereset_writes", wr_cnt - base, 8);
    rst_ni = 1'b0;
    #1;
    chk("inreset_wren", {31'b0, wren}, 0);
    chk("inreset_busy", {31'b0, busy}, 0);
    send_px(0, 32, 4, 1'b0);
    rst_ni = 1'b1;
    send_px(0, 36, 28, 1'b0);
    line_end();
    for (int y = 1; y < 4; y++) send_line(y, 8, 1'b0);
    drain();
    chk("postreset_writes", wr_cnt - base, 8);
    frame_start();
    send_line(0, 8, 1'b1);
    drain();
    chk("recover_writes", wr_cnt - base, 10);
    frame_end();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
